keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_debounce.sv | 126 ++++++++++++
 rtl/keypad_scanner.sv | 131 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad scanner: debounce states, frame results
// and the key-code to ASCII mapping used for the Hack KBD register.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } db_state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_res_t;

    // Indexed by row*4 + column; rows read "123A", "456B", "789C", "*0#D".
    localparam logic [7:0] KEY_ASCII [16] = '{
        8'h31, 8'h32, 8'h33, 8'h41,
        8'h34, 8'h35, 8'h36, 8'h42,
        8'h37, 8'h38, 8'h39, 8'h43,
        8'h2A, 8'h30, 8'h23, 8'h44
    };

    function automatic logic [15:0] key_to_kbd(input logic [3:0] code);
        return {8'h00, KEY_ASCII[code]};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM: turns a stream of per-frame scan results into
// single accept and release events for one key at a time.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_valid,
    input  frame_res_t frame_res,
    input  logic [3:0] frame_code,
    output logic       accept,
    output logic       release_key,
    output logic [3:0] accept_code
);

    localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_FRAMES);

    db_state_t  state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] cand, cand_next;
    logic [3:0] cnt_inc;
    logic       is_single, is_none, single_match;

    assign cnt_inc      = cnt + 4'd1;
    assign is_single    = (frame_res == FR_SINGLE);
    assign is_none      = (frame_res == FR_NONE);
    assign single_match = is_single && (frame_code == cand);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            cand  <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cand  <= cand_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        if (frame_valid) begin
            case (state)
                ST_IDLE: begin
                    if (is_single) begin
                        cand_next = frame_code;
                        if (DB_TARGET == 4'd1) begin
                            state_next = ST_HELD;
                            cnt_next   = 4'd0;
                        end else begin
                            state_next = ST_PRESS_DB;
                            cnt_next   = 4'd1;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (!single_match) begin
                        state_next = ST_IDLE;
                        cnt_next   = 4'd0;
                    end else if (cnt_inc == DB_TARGET) begin
                        state_next = ST_HELD;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (is_none) begin
                        if (DB_TARGET == 4'd1) begin
                            state_next = ST_IDLE;
                            cnt_next   = 4'd0;
                        end else begin
                            state_next = ST_RELEASE_DB;
                            cnt_next   = 4'd1;
                        end
                    end
                end
                ST_RELEASE_DB: begin
                    // Any key seen during release debounce counts as still held.
                    if (!is_none) begin
                        state_next = ST_HELD;
                        cnt_next   = 4'd0;
                    end else if (cnt_inc == DB_TARGET) begin
                        state_next = ST_IDLE;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        accept      = 1'b0;
        release_key = 1'b0;
        accept_code = cand;
        if (frame_valid) begin
            case (state)
                ST_IDLE: begin
                    if (is_single && DB_TARGET == 4'd1) begin
                        accept      = 1'b1;
                        accept_code = frame_code;
                    end
                end
                ST_PRESS_DB:   accept      = single_match && (cnt_inc == DB_TARGET);
                ST_HELD:       release_key = is_none && (DB_TARGET == 4'd1);
                ST_RELEASE_DB: release_key = is_none && (cnt_inc == DB_TARGET);
                default: begin
                    accept      = 1'b0;
                    release_key = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, column sampling, per-frame
// classification, debounce, a valid/ready event port and a Hack KBD value.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [15:0] kbd,
    output logic        key_overrun
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc;
    logic          tick;
    logic [3:0]    col_meta, col_sync;
    logic [1:0]    row_idx;

    logic          acc_found, acc_multi;
    logic [3:0]    acc_code;
    logic [3:0]    row_low;
    logic [1:0]    col_idx;
    logic          sample_none, sample_one;
    logic          merged_found, merged_multi;
    logic [3:0]    merged_code;
    logic          frame_valid;
    frame_res_t    frame_res;

    logic          accept, release_key;
    logic [3:0]    accept_code;

    assign tick        = (presc == PW'(SCAN_DIV - 1));
    assign row         = ~(4'b0001 << row_idx);
    assign frame_valid = tick && (row_idx == 2'd3);

    always_ff @(posedge clk50) begin
        if (rst) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            presc   <= '0;
            row_idx <= 2'd0;
        end else if (tick) begin
            presc   <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Fold the current row's sample into what this frame has already seen.
    always_comb begin
        row_low     = ~col_sync;
        sample_none = (row_low == 4'd0);
        sample_one  = $onehot(row_low);
        col_idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (row_low[i]) col_idx = 2'(i);
        end
        merged_found = acc_found | sample_one;
        merged_multi = acc_multi | (!sample_none && !sample_one) | (acc_found & sample_one);
        merged_code  = acc_found ? acc_code : {row_idx, col_idx};
        if (merged_multi)      frame_res = FR_MULTI;
        else if (merged_found) frame_res = FR_SINGLE;
        else                   frame_res = FR_NONE;
    end

    always_ff @(posedge clk50) begin
        if (rst || frame_valid) begin
            acc_found <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else if (tick) begin
            acc_found <= merged_found;
            acc_multi <= merged_multi;
            acc_code  <= merged_code;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk         (clk50),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_res   (frame_res),
        .frame_code  (merged_code),
        .accept      (accept),
        .release_key (release_key),
        .accept_code (accept_code)
    );

    // A new press replaces the pending one only if the consumer takes it now.
    always_ff @(posedge clk50) begin
        if (rst) begin
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
            kbd         <= 16'd0;
        end else begin
            if (accept) begin
                kbd <= key_to_kbd(accept_code);
                if (!key_valid || key_ready) begin
                    key_code  <= accept_code;
                    key_valid <= 1'b1;
                end else begin
                    key_overrun <= 1'b1;
                end
            end else begin
                if (release_key) kbd <= 16'd0;
                if (key_valid && key_ready) key_valid <= 1'b0;
            end
        end
    end

endmodule
